// File: rtl/pdp8_kw_pkg.sv
// Shared constants and types for the KW8/I line-clock timebase.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdp8_kw_pkg;

    // Accumulator width of the fractional divider; large enough for a 50 MHz clock.
    localparam int ACC_W = 26;

    localparam int unsigned SYS_CLK_DEF  = 50_000_000;
    localparam int unsigned CLK_RATE_DEF = 60;
    localparam int unsigned DEB_CYC_DEF  = 1000;
    localparam int          PEND_W_DEF   = 3;

    // Debounce FSM encoding, shared with the controller and the bench.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        RISE_WAIT   = 2'd1,
        HIGH_STABLE = 2'd2,
        FALL_WAIT   = 2'd3
    } deb_state_t;

endpackage

// File: rtl/pdp8_kw_tick_if.sv
// Controller <-> timebase bundle: enable/select/ack controls in, pending-tick status out.
// Latency: n/a (wiring only).
// Backpressure: the controller consumes ticks with tick_ack; unconsumed ticks queue in pend_cnt.
interface pdp8_kw_tick_if #(
    parameter int PEND_W = 3
);
    logic              enable;
    logic              rate_sel;
    logic              tick_ack;
    logic              overrun_clr;
    logic              tick_req;
    logic [PEND_W-1:0] pend_cnt;
    logic              overrun;

    // Controller side.
    modport master (
        output enable, rate_sel, tick_ack, overrun_clr,
        input  tick_req, pend_cnt, overrun
    );

    // Timebase side.
    modport slave (
        input  enable, rate_sel, tick_ack, overrun_clr,
        output tick_req, pend_cnt, overrun
    );
endinterface

// File: rtl/pdp8_line_debounce.sv
// Synchronizes and debounces the external line-frequency input; pulses once per accepted rising edge.
// Latency: 2 sync stages + DEB_CYC stable samples + 1 registered pulse.
// Backpressure: none; free-running, the pulse is a single-cycle strobe.
// Ports: clk, reset (async active-high), line_in (async), rise_pulse (1-cycle, registered).
module pdp8_line_debounce
    import pdp8_kw_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic rise_pulse
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    // The sample that leaves a stable state counts as the first of DEB_CYC,
    // so the level is accepted when the count lands on DEB_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1;
    logic             ls;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, cnt_nxt;
    logic             rise_nxt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = deb_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            ls         <= 1'b0;
            state      <= LOW_STABLE;
            deb_cnt    <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= line_in;
            ls         <= sync1;
            state      <= state_nxt;
            deb_cnt    <= cnt_nxt;
            rise_pulse <= rise_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = deb_cnt;
        rise_nxt  = 1'b0;
        case (state)
            LOW_STABLE: begin
                if (ls) begin
                    state_nxt = RISE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RISE_WAIT: begin
                if (!ls) begin
                    state_nxt = LOW_STABLE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_nxt = HIGH_STABLE;
                        rise_nxt  = 1'b1;
                    end
                end
            end
            HIGH_STABLE: begin
                if (!ls) begin
                    state_nxt = FALL_WAIT;
                    cnt_nxt   = '0;
                end
            end
            FALL_WAIT: begin
                if (ls) begin
                    state_nxt = HIGH_STABLE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_nxt = LOW_STABLE;
                    end
                end
            end
            default: state_nxt = LOW_STABLE;
        endcase
    end

endmodule

// File: rtl/pdp8_kw_tick.sv
// Line-clock timebase feeding the KW8/I controller: fractional divider or debounced line input, queued in a saturating counter.
// Latency: tick to tick_req = 1 clk; all outputs registered.
// Backpressure: ticks queue in pend_cnt until tick_ack; at saturation extra ticks are dropped and overrun is set.
// Ports: clk, reset (async active-high), line_in (async), bus (pdp8_kw_tick_if.slave: enable, rate_sel,
//        tick_ack, overrun_clr in; tick_req, pend_cnt, overrun out).
module pdp8_kw_tick
    import pdp8_kw_pkg::*;
#(
    parameter int unsigned SYS_CLK  = SYS_CLK_DEF,
    parameter int unsigned CLK_RATE = CLK_RATE_DEF,
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int          PEND_W   = PEND_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_in,
    pdp8_kw_tick_if.slave         bus
);

    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [SUM_W-1:0]  acc_sum;
    logic              tick_int;
    logic              tick_ext;
    logic              tick;
    logic              ack;
    logic [PEND_W-1:0] pend_cnt, pend_nxt;
    logic              tick_req;
    logic              overrun, overrun_nxt;
    logic              ovr_set;

    pdp8_line_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk        (clk),
        .reset      (reset),
        .line_in    (line_in),
        .rise_pulse (tick_ext)
    );

    // One extra bit so acc+CLK_RATE never wraps before the compare.
    assign acc_sum  = {1'b0, acc} + SUM_W'(CLK_RATE);
    assign tick_int = (acc_sum >= SUM_W'(SYS_CLK));

    // The accumulator only advances while the divider is the selected source,
    // so switching sources neither loses nor invents phase.
    always_comb begin
        acc_nxt = acc;
        if (!bus.enable) begin
            acc_nxt = '0;
        end else if (!bus.rate_sel) begin
            if (tick_int) begin
                acc_nxt = ACC_W'(acc_sum - SUM_W'(SYS_CLK));
            end else begin
                acc_nxt = acc_sum[ACC_W-1:0];
            end
        end
    end

    assign tick = bus.enable & (bus.rate_sel ? tick_ext : tick_int);
    // Acks only count while something is actually pending.
    assign ack  = bus.tick_ack & tick_req;

    always_comb begin
        pend_nxt = pend_cnt;
        ovr_set  = 1'b0;
        if (!bus.enable) begin
            pend_nxt = '0;
        end else if (tick && !ack) begin
            if (&pend_cnt) begin
                ovr_set = 1'b1;
            end else begin
                pend_nxt = pend_cnt + PEND_W'(1);
            end
        end else if (ack && !tick) begin
            pend_nxt = pend_cnt - PEND_W'(1);
        end
    end

    // A saturating tick in the same cycle as overrun_clr keeps the flag set.
    assign overrun_nxt = ovr_set | (overrun & ~bus.overrun_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            pend_cnt <= '0;
            tick_req <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            acc      <= acc_nxt;
            pend_cnt <= pend_nxt;
            tick_req <= (pend_nxt != '0);
            overrun  <= overrun_nxt;
        end
    end

    assign bus.pend_cnt = pend_cnt;
    assign bus.tick_req = tick_req;
    assign bus.overrun  = overrun;

endmodule

// File: doc/pdp8_kw_tick.md
Name: pdp8_kw_tick

Overview:
- Line-clock timebase that sits directly upstream of the KW8/I clock controller.
- Produces the clock-rollover request that the controller samples to set its clock flag.
- Generates ticks from a fractional divider of the system clock, or from a debounced external line-frequency input.
- Queues ticks in a saturating pending counter so that none are lost while the consumer waits for its acknowledge cycle.

Parameters:
SYS_CLK, 50000000, system clock frequency in Hz (26-bit).
CLK_RATE, 60, internal tick rate in Hz; must be less than SYS_CLK.
DEB_CYC, 1000, number of consecutive stable synchronized samples required to accept a line_in level change.
PEND_W, 3, width of the pending-tick counter.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  clock enable from the controller (its clock-enable bit).
rate_sel  input  1  0 = internal fractional divider, 1 = external line_in.
line_in  input  1  asynchronous line-frequency square wave.
tick_ack  input  1  one-cycle consume strobe from the controller (its F3 sample).
overrun_clr  input  1  clears the overrun flag.
tick_req  output  1  high while pend_cnt is nonzero.
pend_cnt  output  PEND_W  number of unconsumed ticks.
overrun  output  1  sticky; a tick arrived while pend_cnt was at its maximum.

Behaviour:
- Reset (asynchronous): acc=0, sync FFs=0, debounce state LOW_STABLE, deb_cnt=0, pend_cnt=0, tick_req=0, overrun=0.
- Internal divider (rate_sel=0, enable=1), evaluated every clk:
  - 26-bit acc.
  - If acc+CLK_RATE >= SYS_CLK: acc <= acc+CLK_RATE-SYS_CLK and tick_int=1.
  - Otherwise: acc <= acc+CLK_RATE.
  - Long-run average is exactly CLK_RATE ticks/s. Jitter is at most 1 cycle.
- External path:
  - line_in passes through a 2-FF synchronizer, giving ls.
  - Debounce FSM states: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT.
  - LOW_STABLE goes to RISE_WAIT when ls=1; deb_cnt is cleared.
  - RISE_WAIT increments deb_cnt while ls=1. It returns to LOW_STABLE if ls=0. When deb_cnt reaches DEB_CYC-1 it goes to HIGH_STABLE and asserts tick_ext for one cycle.
  - HIGH_STABLE and FALL_WAIT mirror this for the falling edge, with no tick.
  - The FSM runs regardless of enable. tick_ext counts only when enable=1 and rate_sel=1.
- tick = enable & (rate_sel ? tick_ext : tick_int).
- enable=0: acc is held at 0 and pend_cnt is cleared to 0. overrun is retained.
- Changing rate_sel mid-operation causes no spurious tick. acc is not reset.
- Pending counter, per cycle (ack = tick_ack & tick_req):
  - tick and no ack: increment. If pend_cnt is already all ones, hold it and set overrun.
  - ack and no tick: decrement.
  - tick and ack together: unchanged.
  - tick_ack while pend_cnt=0: ignored.
- tick_req is registered and equals (pend_cnt != 0). Latency from tick to tick_req=1 is 1 clk.
- overrun_clr clears overrun. If overrun_clr and a saturating tick occur in the same cycle, overrun stays set (set wins).
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Shared package pdp8_kw_pkg: SYS_CLK/CLK_RATE defaults and the debounce state encoding, reused by the controller and the bench.
- One natural sub-module: pdp8_line_debounce, containing the synchronizer, debounce FSM and deb_cnt, with a rising-edge pulse output.

Test Plan:
1. SYS_CLK=10, CLK_RATE=3, enable=1, rate_sel=0, tick_ack=0 -> ticks on cycles 4, 7 and 10 after enable; pend_cnt reads 1, 2, 3 one cycle after each tick; 3 ticks per 10 cycles indefinitely.
2. Same setup, tick_ack pulsed in the same cycle as a tick with pend_cnt=2 -> pend_cnt stays 2; tick_ack with pend_cnt=0 -> stays 0 and tick_req stays 0.
3. PEND_W=3, no acks -> pend_cnt saturates at 7; the 8th tick sets overrun=1 and pend_cnt stays 7; overrun_clr -> overrun=0; next tick -> overrun=1 again.
4. DEB_CYC=4, rate_sel=1:
   - line_in high for 3 cycles, then low -> no tick.
   - line_in high for 10 cycles -> exactly one tick, then pend_cnt=1.
   - falling edge -> no tick.
5. enable dropped with pend_cnt=5 -> next cycle pend_cnt=0, tick_req=0, acc=0; re-enable -> first tick after 4 cycles (SYS_CLK=10, CLK_RATE=3).
6. reset asserted mid-count, asynchronously between clock edges -> all outputs 0 immediately without a clock edge; operation resumes after release.
